mgc_axi_rd_arbiter: RTL and testbench

- Shares one AXI read-channel master port (AR + R) between NUM_REQ upstream requesters.
- Arbitrates AR requests round-robin and prefixes each requester's ARID with its index.
- Routes R beats back to the requester selected by the upper ID bits.
- Enforces a per-requester outstanding-burst limit.
- Sits between test/stimulus requesters and the AXI master BFM port.

---
 rtl/mgc_axi_rd_arbiter.sv | 159 +++++++++++++++
 tb/tb_mgc_axi_rd_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgc_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master (AR + R) between NUM_REQ requesters,
// with requester-index ID prefixing, R routing and per-requester outstanding-burst limits.
module mgc_axi_rd_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int RDATA_WIDTH     = 32,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 8,
   localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_arvalid,
   output logic [NUM_REQ-1:0]              req_arready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_araddr,
   input  logic [NUM_REQ*ID_WIDTH-1:0]     req_arid,
   input  logic [NUM_REQ*8-1:0]            req_arlen,
   output logic                            m_arvalid,
   input  logic                            m_arready,
   output logic [ADDR_WIDTH-1:0]           m_araddr,
   output logic [ID_WIDTH+IDX_W-1:0]       m_arid,
   output logic [7:0]                      m_arlen,
   input  logic                            m_rvalid,
   output logic                            m_rready,
   input  logic [RDATA_WIDTH-1:0]          m_rdata,
   input  logic [ID_WIDTH+IDX_W-1:0]       m_rid,
   input  logic [1:0]                      m_rresp,
   input  logic                            m_rlast,
   output logic [NUM_REQ-1:0]              req_rvalid,
   input  logic [NUM_REQ-1:0]              req_rready,
   output logic [RDATA_WIDTH-1:0]          req_rdata,
   output logic [ID_WIDTH-1:0]             req_rid,
   output logic [1:0]                      req_rresp,
   output logic                            req_rlast,
   output logic                            err_unmapped
);

   localparam int DID_W = ID_WIDTH + IDX_W;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, ADDR} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [DID_W-1:0]      arid_q, arid_d;
   logic [7:0]            arlen_q, arlen_d;
   logic [CNT_W-1:0]      cnt_q [NUM_REQ];
   logic [CNT_W-1:0]      cnt_d [NUM_REQ];

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    inc_vec;
   logic [NUM_REQ-1:0]    dec_vec;
   logic                  grant_vld;
   logic [IDX_W-1:0]      grant_idx;
   int                    cand;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_mapped;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr_q) + k) % NUM_REQ;
         if (!grant_vld && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      araddr_d    = araddr_q;
      arid_d      = arid_q;
      arlen_d     = arlen_q;
      req_arready = '0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               req_arready[grant_idx] = 1'b1;
               araddr_d = req_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
               arid_d   = {grant_idx, req_arid[grant_idx*ID_WIDTH +: ID_WIDTH]};
               arlen_d  = req_arlen[grant_idx*8 +: 8];
               ptr_d    = grant_idx;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            if (m_arready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_arvalid = (state_q == ADDR);
   assign m_araddr  = araddr_q;
   assign m_arid    = arid_q;
   assign m_arlen   = arlen_q;

   // Upper ID bits carry the requester index stamped on the AR side.
   assign r_idx        = m_rid[DID_W-1 -: IDX_W];
   assign r_mapped     = (int'(r_idx) < NUM_REQ);
   assign err_unmapped = m_rvalid && !r_mapped;

   always_comb begin
      req_rvalid = '0;
      m_rready   = !r_mapped;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_mapped && (r_idx == IDX_W'(i))) begin
            req_rvalid[i] = m_rvalid;
            m_rready      = req_rready[i];
         end
      end
   end

   assign req_rdata = m_rdata;
   assign req_rid   = m_rid[ID_WIDTH-1:0];
   assign req_rresp = m_rresp;
   assign req_rlast = m_rlast;

   // A decrement at zero is dropped so a stray rlast cannot underflow the count.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         inc_vec[i] = (state_q == IDLE) && grant_vld && (grant_idx == IDX_W'(i));
         dec_vec[i] = m_rvalid && m_rready && m_rlast && r_mapped &&
                      (r_idx == IDX_W'(i)) && (cnt_q[i] != '0);
         cnt_d[i]   = cnt_q[i];
         if (inc_vec[i] && !dec_vec[i])
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         else if (dec_vec[i] && !inc_vec[i])
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= IDX_W'(NUM_REQ - 1);
         araddr_q <= '0;
         arid_q   <= '0;
         arlen_q  <= '0;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         araddr_q <= araddr_d;
         arid_q   <= arid_d;
         arlen_q  <= arlen_d;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_mgc_axi_rd_arbiter.sv
// Bench for mgc_axi_rd_arbiter: 3 requesters, limit 3; AR beats scored against a queue
// of predicted grants, timing and routing checked inline per scenario.
module tb_mgc_axi_rd_arbiter;

   localparam int NR  = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int IW  = 4;
   localparam int MO  = 3;
   localparam int DIW = IW + 2;

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic [DIW-1:0] id;
      logic [7:0]     len;
   } ar_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_arvalid;
   logic [NR-1:0]     req_arready;
   logic [NR*AW-1:0]  req_araddr;
   logic [NR*IW-1:0]  req_arid;
   logic [NR*8-1:0]   req_arlen;
   logic              m_arvalid;
   logic              m_arready;
   logic [AW-1:0]     m_araddr;
   logic [DIW-1:0]    m_arid;
   logic [7:0]        m_arlen;
   logic              m_rvalid;
   logic              m_rready;
   logic [DW-1:0]     m_rdata;
   logic [DIW-1:0]    m_rid;
   logic [1:0]        m_rresp;
   logic              m_rlast;
   logic [NR-1:0]     req_rvalid;
   logic [NR-1:0]     req_rready;
   logic [DW-1:0]     req_rdata;
   logic [IW-1:0]     req_rid;
   logic [1:0]        req_rresp;
   logic              req_rlast;
   logic              err_unmapped;

   int  checks = 0;
   int  passes = 0;
   ar_t exp_q[$];

   mgc_axi_rd_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .RDATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
      .req_arid(req_arid), .req_arlen(req_arlen),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arid(m_arid), .m_arlen(m_arlen),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
      .req_rid(req_rid), .req_rresp(req_rresp), .req_rlast(req_rlast),
      .err_unmapped(err_unmapped)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Downstream AR handshakes are scored between edges, after the tasks have driven inputs.
   initial begin
      ar_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && m_arvalid && m_arready) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL ar_unexpected: got addr=%h id=%h len=%h, none expected",
                        m_araddr, m_arid, m_arlen);
            end else begin
               e = exp_q.pop_front();
               if ({m_araddr, m_arid, m_arlen} !== e)
                  $display("FAIL ar_beat: got addr=%h id=%h len=%h expected addr=%h id=%h len=%h",
                           m_araddr, m_arid, m_arlen, e.addr, e.id, e.len);
               else passes++;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ar(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [IW-1:0] id, input logic [7:0] len);
      req_arvalid[i]         = v;
      req_araddr[i*AW +: AW] = a;
      req_arid[i*IW +: IW]   = id;
      req_arlen[i*8 +: 8]    = len;
   endtask

   task automatic push_exp(input int i, input logic [AW-1:0] a,
                           input logic [IW-1:0] id, input logic [7:0] len);
      ar_t e;
      e.addr = a;
      e.id   = {2'(i), id};
      e.len  = len;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      req_arvalid = '0; req_araddr = '0; req_arid = '0; req_arlen = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0;
      m_rresp = '0; m_rlast = 1'b0; req_rready = '0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      idle_inputs();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) tick();
      #1;
      checks++;
      if (m_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b expected 0", m_arvalid);
      else passes++;
      checks++;
      if (req_arready !== 3'b000) $display("FAIL rst_arready: got %b expected 000", req_arready);
      else passes++;
      checks++;
      if ({m_araddr, m_arid, m_arlen} !== '0)
         $display("FAIL rst_payload: got %h/%h/%h expected 0", m_araddr, m_arid, m_arlen);
      else passes++;
      checks++;
      if (err_unmapped !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_unmapped);
      else passes++;
   endtask

   task automatic test_single();
      do_reset();
      m_arready = 1'b1;
      set_ar(0, 1'b1, 32'h1000, 4'd3, 8'd7);
      push_exp(0, 32'h1000, 4'd3, 8'd7);
      #1;
      checks++;
      if ({req_arready, m_arvalid} !== 4'b0010)
         $display("FAIL single_grant: got arready=%b arvalid=%b expected 001/0", req_arready, m_arvalid);
      else passes++;
      tick();
      set_ar(0, 1'b0, 32'h1000, 4'd3, 8'd7);
      #1;
      checks++;
      if ({m_arvalid, m_arid, m_arlen, req_arready} !== {1'b1, 6'h03, 8'd7, 3'b000})
         $display("FAIL single_addr: got arvalid=%b id=%h len=%h arready=%b expected 1/03/07/000",
                  m_arvalid, m_arid, m_arlen, req_arready);
      else passes++;
      tick();
      #1;
      checks++;
      if (m_arvalid !== 1'b0) $display("FAIL single_idle: got %b expected 0", m_arvalid);
      else passes++;
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] exp_rdy;
      do_reset();
      m_arready = 1'b1;
      for (int i = 0; i < NR; i++) set_ar(i, 1'b1, 32'h100 * (i + 1), 4'(i + 1), 8'(16 * i));
      for (int g = 0; g < 6; g++) push_exp(g % NR, 32'h100 * (g % NR + 1), 4'(g % NR + 1), 8'(16 * (g % NR)));
      for (int k = 0; k < 12; k++) begin
         #1;
         checks++;
         if (k % 2 == 0) begin
            exp_rdy = 3'(1 << ((k / 2) % NR));
            if ({m_arvalid, req_arready} !== {1'b0, exp_rdy})
               $display("FAIL rr_idle_%0d: got arvalid=%b arready=%b expected 0/%b",
                        k, m_arvalid, req_arready, exp_rdy);
            else passes++;
         end else begin
            if ({m_arvalid, req_arready} !== 4'b1000)
               $display("FAIL rr_addr_%0d: got arvalid=%b arready=%b expected 1/000",
                        k, m_arvalid, req_arready);
            else passes++;
         end
         tick();
      end
      req_arvalid = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      m_arready = 1'b0;
      set_ar(1, 1'b1, 32'h2000, 4'd5, 8'd3);
      push_exp(1, 32'h2000, 4'd5, 8'd3);
      #1;
      checks++;
      if (req_arready !== 3'b010) $display("FAIL bp_grant: got %b expected 010", req_arready);
      else passes++;
      tick();
      set_ar(1, 1'b0, 32'h2000, 4'd5, 8'd3);
      set_ar(0, 1'b1, 32'h2400, 4'd9, 8'd1);
      push_exp(0, 32'h2400, 4'd9, 8'd1);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if ({m_arvalid, m_araddr, m_arid, m_arlen, req_arready} !==
             {1'b1, 32'h2000, 6'h15, 8'd3, 3'b000})
            $display("FAIL bp_hold_%0d: got arvalid=%b addr=%h id=%h len=%h arready=%b",
                     k, m_arvalid, m_araddr, m_arid, m_arlen, req_arready);
         else passes++;
         if (k == 4) m_arready = 1'b1;
         tick();
      end
      #1;
      checks++;
      if ({m_arvalid, req_arready} !== 4'b0001)
         $display("FAIL bp_next: got arvalid=%b arready=%b expected 0/001", m_arvalid, req_arready);
      else passes++;
      tick();
      set_ar(0, 1'b0, 32'h2400, 4'd9, 8'd1);
      tick();
   endtask

   task automatic test_limit();
      do_reset();
      m_arready = 1'b1;
      set_ar(1, 1'b1, 32'h3000, 4'd2, 8'd0);
      for (int g = 0; g < MO; g++) begin
         push_exp(1, 32'h3000, 4'd2, 8'd0);
         #1;
         checks++;
         if (req_arready !== 3'b010) $display("FAIL limit_grant_%0d: got %b expected 010", g, req_arready);
         else passes++;
         tick();
         tick();
      end
      #1;
      checks++;
      if (req_arready !== 3'b000) $display("FAIL limit_stall: got %b expected 000", req_arready);
      else passes++;
      tick();
      #1;
      checks++;
      if (m_arvalid !== 1'b0) $display("FAIL limit_no_ar: got %b expected 0", m_arvalid);
      else passes++;
      set_ar(0, 1'b1, 32'h3400, 4'd7, 8'd2);
      push_exp(0, 32'h3400, 4'd7, 8'd2);
      #1;
      checks++;
      if (req_arready !== 3'b001) $display("FAIL limit_other: got %b expected 001", req_arready);
      else passes++;
      tick();
      set_ar(0, 1'b0, 32'h3400, 4'd7, 8'd2);
      tick();
      m_rvalid = 1'b1; m_rid = {2'd1, 4'd2}; m_rlast = 1'b1; req_rready = 3'b010;
      #1;
      checks++;
      if ({req_arready, req_rvalid, m_rready} !== {3'b000, 3'b010, 1'b1})
         $display("FAIL limit_pre_release: got arready=%b rvalid=%b rready=%b expected 000/010/1",
                  req_arready, req_rvalid, m_rready);
      else passes++;
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0; req_rready = '0;
      push_exp(1, 32'h3000, 4'd2, 8'd0);
      #1;
      checks++;
      if (req_arready !== 3'b010) $display("FAIL limit_release: got %b expected 010", req_arready);
      else passes++;
      tick();
      set_ar(1, 1'b0, 32'h3000, 4'd2, 8'd0);
      tick();
   endtask

   task automatic test_routing();
      do_reset();
      m_rvalid = 1'b1; m_rid = {2'd2, 4'd5}; m_rdata = 32'hCAFE_0002;
      m_rresp = 2'b10; m_rlast = 1'b0; req_rready = 3'b011;
      #1;
      checks++;
      if ({req_rvalid, m_rready, err_unmapped} !== 5'b10000)
         $display("FAIL route_blocked: got rvalid=%b rready=%b err=%b expected 100/0/0",
                  req_rvalid, m_rready, err_unmapped);
      else passes++;
      checks++;
      if ({req_rid, req_rdata, req_rresp, req_rlast} !== {4'd5, 32'hCAFE_0002, 2'b10, 1'b0})
         $display("FAIL route_bcast: got id=%h data=%h resp=%b last=%b", req_rid, req_rdata, req_rresp, req_rlast);
      else passes++;
      req_rready = 3'b100;
      #1;
      checks++;
      if (m_rready !== 1'b1) $display("FAIL route_ready: got %b expected 1", m_rready);
      else passes++;
      m_rid = {2'd3, 4'd5}; req_rready = 3'b000;
      #1;
      checks++;
      if ({req_rvalid, m_rready, err_unmapped} !== 5'b00011)
         $display("FAIL route_unmapped: got rvalid=%b rready=%b err=%b expected 000/1/1",
                  req_rvalid, m_rready, err_unmapped);
      else passes++;
      m_rvalid = 1'b0;
      #1;
      checks++;
      if ({err_unmapped, m_rready} !== 2'b01)
         $display("FAIL route_unmapped_idle: got err=%b rready=%b expected 0/1", err_unmapped, m_rready);
      else passes++;
      m_rid = {2'd0, 4'd1}; m_rvalid = 1'b1; req_rready = 3'b001;
      #1;
      checks++;
      if ({req_rvalid, m_rready} !== 4'b0011)
         $display("FAIL route_req0: got rvalid=%b rready=%b expected 001/1", req_rvalid, m_rready);
      else passes++;
      tick();
      m_rvalid = 1'b0; req_rready = '0;
   endtask

   task automatic test_saturate();
      do_reset();
      m_arready = 1'b1;
      m_rvalid = 1'b1; m_rid = {2'd0, 4'd0}; m_rlast = 1'b1; req_rready = 3'b001;
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0; req_rready = '0;
      set_ar(0, 1'b1, 32'h5000, 4'd1, 8'd4);
      for (int g = 0; g < MO; g++) begin
         push_exp(0, 32'h5000, 4'd1, 8'd4);
         #1;
         checks++;
         if (req_arready !== 3'b001) $display("FAIL sat_grant_%0d: got %b expected 001", g, req_arready);
         else passes++;
         tick();
         tick();
      end
      #1;
      checks++;
      if (req_arready !== 3'b000) $display("FAIL sat_limit: got %b expected 000", req_arready);
      else passes++;
      set_ar(0, 1'b0, 32'h5000, 4'd1, 8'd4);
      tick();
   endtask

   task automatic test_reset_mid();
      logic [NR-1:0] exp_rdy;
      do_reset();
      m_arready = 1'b1;
      set_ar(0, 1'b1, 32'h6000, 4'd0, 8'd0);
      for (int g = 0; g < MO; g++) begin
         push_exp(0, 32'h6000, 4'd0, 8'd0);
         tick();
         tick();
      end
      set_ar(0, 1'b0, 32'h6000, 4'd0, 8'd0);
      set_ar(1, 1'b1, 32'h6400, 4'd1, 8'd0);
      m_arready = 1'b0;
      #1;
      checks++;
      if (req_arready !== 3'b010) $display("FAIL rstmid_grant1: got %b expected 010", req_arready);
      else passes++;
      tick();
      set_ar(1, 1'b0, 32'h6400, 4'd1, 8'd0);
      #1;
      checks++;
      if (m_arvalid !== 1'b1) $display("FAIL rstmid_pending: got %b expected 1", m_arvalid);
      else passes++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({m_arvalid, m_araddr, m_arid, m_arlen} !== '0)
         $display("FAIL rstmid_cleared: got arvalid=%b addr=%h id=%h len=%h expected 0",
                  m_arvalid, m_araddr, m_arid, m_arlen);
      else passes++;
      m_arready = 1'b1;
      set_ar(0, 1'b1, 32'h7000, 4'd4, 8'd1);
      set_ar(1, 1'b1, 32'h7400, 4'd6, 8'd2);
      for (int g = 0; g < 6; g++) begin
         if (g % 2 == 0) push_exp(0, 32'h7000, 4'd4, 8'd1);
         else            push_exp(1, 32'h7400, 4'd6, 8'd2);
      end
      for (int k = 0; k < 12; k++) begin
         #1;
         if (k % 2 == 0) begin
            exp_rdy = ((k / 2) % 2 == 0) ? 3'b001 : 3'b010;
            checks++;
            if (req_arready !== exp_rdy)
               $display("FAIL rstmid_rr_%0d: got %b expected %b", k, req_arready, exp_rdy);
            else passes++;
         end
         tick();
      end
      req_arvalid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_limit();
      test_routing();
      test_saturate();
      test_reset_mid();
      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
